// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - big-endian byte memory answering SPARC-style load/store requests with fixed latency
// IDLE latches a request, ACCESS counts down the latency, DONE holds MFC until the requester drops enable.
module mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 512
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ram_enable_i,
  input  logic [5:0]  ram_opcode_i,
  input  logic [31:0] address_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic        mfc_o,
  output logic        merr_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [5:0]      op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     din_q, din_d;
  logic [31:0]     dout_q, dout_d;
  logic            mfc_q, mfc_d;
  logic            merr_q, merr_d;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   byte_addr [4];
  logic [7:0]      rd_byte [4];
  logic [7:0]      wr_byte [4];
  logic [3:0]      wr_en;

  logic            is_valid, is_load, is_signed, is_half, is_word, fault;
  logic [31:0]     load_data;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^address_i[31:AW];

  // Byte lanes in big-endian order; the AW-bit add wraps modulo DEPTH.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      byte_addr[k] = addr_q + AW'(k);
      rd_byte[k]   = mem[byte_addr[k]];
    end
  end

  always_comb begin
    is_valid  = 1'b1;
    is_load   = 1'b0;
    is_signed = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    case (op_q)
      OP_LD:   begin is_load = 1'b1; is_word = 1'b1; end
      OP_LDUB: begin is_load = 1'b1; end
      OP_LDUH: begin is_load = 1'b1; is_half = 1'b1; end
      OP_LDSB: begin is_load = 1'b1; is_signed = 1'b1; end
      OP_LDSH: begin is_load = 1'b1; is_signed = 1'b1; is_half = 1'b1; end
      OP_ST:   begin is_word = 1'b1; end
      OP_STB:  ;
      OP_STH:  begin is_half = 1'b1; end
      default: is_valid = 1'b0;
    endcase
    fault = !is_valid || (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
  end

  always_comb begin
    load_data = 32'h0;
    wr_byte[0] = 8'h0;
    wr_byte[1] = 8'h0;
    wr_byte[2] = 8'h0;
    wr_byte[3] = 8'h0;
    wr_en      = 4'b0000;
    if (is_word) begin
      load_data = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
      wr_byte[0] = din_q[31:24];
      wr_byte[1] = din_q[23:16];
      wr_byte[2] = din_q[15:8];
      wr_byte[3] = din_q[7:0];
      wr_en      = 4'b1111;
    end else if (is_half) begin
      load_data = {{16{is_signed & rd_byte[0][7]}}, rd_byte[0], rd_byte[1]};
      wr_byte[0] = din_q[15:8];
      wr_byte[1] = din_q[7:0];
      wr_en      = 4'b0011;
    end else begin
      load_data = {{24{is_signed & rd_byte[0][7]}}, rd_byte[0]};
      wr_byte[0] = din_q[7:0];
      wr_en      = 4'b0001;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    merr_d  = merr_q;
    case (state_q)
      IDLE: begin
        if (ram_enable_i) begin
          op_d    = ram_opcode_i;
          addr_d  = address_i[AW-1:0];
          din_d   = data_in_i;
          cnt_d   = 4'(LATENCY - 1);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mfc_d   = 1'b1;
          merr_d  = fault;
          if (is_load && !fault) dout_d = load_data;
          state_d = DONE;
        end
      end
      DONE: begin
        if (!ram_enable_i) begin
          mfc_d   = 1'b0;
          merr_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 6'd0;
      addr_q  <= '0;
      din_q   <= 32'd0;
      dout_q  <= 32'd0;
      mfc_q   <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      merr_q  <= merr_d;
    end
  end

  // Contents survive reset; a reset on the completing edge suppresses the write.
  always_ff @(posedge clk_i) begin
    if (!reset_i && state_q == ACCESS && cnt_q == 4'd0 && is_valid && !is_load && !fault) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_en[k]) mem[byte_addr[k]] <= wr_byte[k];
      end
    end
  end

  assign data_out_o = dout_q;
  assign mfc_o      = mfc_q;
  assign merr_o     = merr_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - scoreboard bench for mem_responder with directed load/store vectors
module tb_mem_responder;

  localparam int LAT = 2;

  localparam logic [5:0] LD   = 6'b000000;
  localparam logic [5:0] LDUB = 6'b000001;
  localparam logic [5:0] LDUH = 6'b000010;
  localparam logic [5:0] LDD  = 6'b000011;
  localparam logic [5:0] ST   = 6'b000100;
  localparam logic [5:0] STB  = 6'b000101;
  localparam logic [5:0] STH  = 6'b000110;
  localparam logic [5:0] LDSB = 6'b001001;
  localparam logic [5:0] LDSH = 6'b001010;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [5:0]  opcode;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        mfc;
  logic        merr;

  typedef struct {
    logic [31:0] data;
    logic        err;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic mfc_prev = 1'b0;

  mem_responder #(.LATENCY(LAT), .DEPTH(512)) dut (
    .clk_i(clk), .reset_i(reset), .ram_enable_i(en), .ram_opcode_i(opcode),
    .address_i(addr), .data_in_i(din), .data_out_o(dout), .mfc_o(mfc), .merr_o(merr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every rising MFC is matched against the oldest expected response.
  always @(negedge clk) begin
    if (mfc && !mfc_prev) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_mfc: got response 0x%08h with nothing expected", dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_data"}, dout, e.data);
        check({e.name, "_merr"}, {31'd0, merr}, {31'd0, e.err});
      end
    end
    mfc_prev = mfc;
  end

  task automatic issue(input string name, input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_d, input logic exp_m);
    exp_t e;
    @(negedge clk);
    opcode = op;
    addr   = a;
    din    = d;
    en     = 1'b1;
    e.data = exp_d;
    e.err  = exp_m;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  task automatic wait_mfc(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!mfc && n < 20);
    check({name, "_latency"}, 32'(n), 32'(LAT));
  endtask

  task automatic release_req(input string name);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_mfc_drop"}, {31'd0, mfc}, 32'd0);
    check({name, "_merr_drop"}, {31'd0, merr}, 32'd0);
  endtask

  task automatic xfer(input string name, input logic [5:0] op, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] exp_d, input logic exp_m);
    issue(name, op, a, d, exp_d, exp_m);
    wait_mfc(name);
    release_req(name);
  endtask

  initial begin
    logic [31:0] held;
    int          high;
    reset  = 1'b1;
    en     = 1'b0;
    opcode = 6'd0;
    addr   = 32'd0;
    din    = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_dout", dout, 32'd0);
    check("reset_mfc", {31'd0, mfc}, 32'd0);
    check("reset_merr", {31'd0, merr}, 32'd0);
    reset = 1'b0;

    xfer("st_word",   ST,   32'h10, 32'hDEADBEEF, 32'h00000000, 1'b0);
    xfer("ldub",      LDUB, 32'h10, 32'h0,        32'h000000DE, 1'b0);
    xfer("ldsb",      LDSB, 32'h10, 32'h0,        32'hFFFFFFDE, 1'b0);
    xfer("ldsh",      LDSH, 32'h12, 32'h0,        32'hFFFFBEEF, 1'b0);
    xfer("ld_word",   LD,   32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    xfer("stb",       STB,  32'h11, 32'h00000055, 32'hDEADBEEF, 1'b0);
    xfer("ld_after_stb", LD, 32'h10, 32'h0,       32'hDE55BEEF, 1'b0);
    xfer("ld_misalign",  LD, 32'h13, 32'h0,       32'hDE55BEEF, 1'b1);
    xfer("ldd_fault",   LDD, 32'h10, 32'h0,       32'hDE55BEEF, 1'b1);
    xfer("sth_misalign", STH, 32'h11, 32'h00001234, 32'hDE55BEEF, 1'b1);
    xfer("ld_unchanged", LD, 32'h10, 32'h0,       32'hDE55BEEF, 1'b0);
    xfer("lduh",      LDUH, 32'h10, 32'h0,        32'h0000DE55, 1'b0);
    xfer("st_0x20",   ST,   32'h20, 32'h11223344, 32'h0000DE55, 1'b0);

    // Reset held across the two edges that would complete an ST to 0x20.
    @(negedge clk);
    opcode = ST;
    addr   = 32'h20;
    din    = 32'hAABBCCDD;
    en     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    en    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort_mfc", {31'd0, mfc}, 32'd0);
    check("abort_dout", dout, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    xfer("ld_after_abort", LD, 32'h20, 32'h0, 32'h11223344, 1'b0);

    // Enable dropped during ACCESS: access completes and MFC lasts one cycle.
    issue("early_drop", LDUB, 32'h10, 32'h0, 32'h000000DE, 1'b0);
    @(negedge clk);
    en     = 1'b0;
    opcode = ST;
    addr   = 32'h33;
    wait_mfc("early_drop");
    high = 0;
    for (int i = 0; i < 4; i++) begin
      if (mfc) high++;
      @(posedge clk);
      #1;
    end
    check("early_drop_mfc_cycles", 32'(high), 32'd1);

    xfer("ld_wrap", LD, 32'h210, 32'h0, 32'hDE55BEEF, 1'b0);

    // Hold in DONE with inputs that would overwrite 0x10 if re-accepted.
    issue("hold", LDSH, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0);
    wait_mfc("hold");
    held = dout;
    @(negedge clk);
    opcode = ST;
    addr   = 32'h10;
    din    = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_mfc", {31'd0, mfc}, 32'd1);
      check("hold_dout", dout, held);
    end
    release_req("hold");
    xfer("ld_after_hold", LD, 32'h10, 32'h0, 32'hDE55BEEF, 1'b0);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 2, cycles from request acceptance to MFC assertion; legal range 1..15.
REQ-002 Parameter DEPTH, default 512, memory size in bytes; a power of two.
REQ-003 Clk  input  1  sole clock; all state changes on rising edge.
REQ-004 RESET  input  1  reset; synchronous, active-high.
REQ-005 RAM_enable  input  1  request from control unit; held high until MFC observed.
REQ-006 RAM_OpCode  input  6  SPARC op3 access code.
REQ-007 Address  input  32  byte address; only low log2(DEPTH) bits used.
REQ-008 DataIn  input  32  store data.
REQ-009 DataOut  output  32  load result.
REQ-010 MFC  output  1  memory function complete.
REQ-011 MERR  output  1  access fault; valid while MFC high.

Function
REQ-012 FSM states: IDLE, ACCESS, DONE.
REQ-013 IDLE with RAM_enable=1: latch RAM_OpCode, Address, DataIn; load counter with LATENCY-1; go to ACCESS.
REQ-014 ACCESS with counter>0: decrement; latched values only; input changes ignored.
REQ-015 ACCESS with counter=0: perform access; go to DONE; MFC=1 from this edge.
REQ-016 MFC therefore rises exactly LATENCY edges after the edge that sampled the request.
REQ-017 DONE with RAM_enable=1: hold MFC, DataOut, MERR unchanged.
REQ-018 DONE with RAM_enable=0: MFC=0, MERR=0, go to IDLE; DataOut keeps last value.
REQ-019 A new request is accepted only from IDLE, so RAM_enable must be low for at least one edge between requests.
REQ-020 RAM_enable falling during ACCESS does not abort; access completes, DONE lasts one cycle, then IDLE.
REQ-021 Supported codes: LD 000000, LDUB 000001, LDUH 000010, ST 000100, STB 000101, STH 000110, LDSB 001001, LDSH 001010.
REQ-022 Memory is big-endian: the byte at addr is the most significant byte of a half or word.
REQ-023 LD returns the word at addr..addr+3; LDUH/LDUB zero-extend; LDSH/LDSB sign-extend to 32 bits.
REQ-024 ST writes DataIn[31:0]; STH writes DataIn[15:0]; STB writes DataIn[7:0]; other bytes are untouched.
REQ-025 Stores leave DataOut unchanged.
REQ-026 Fault conditions: unsupported code, including LDD 000011; halfword with addr[0]=1; word with addr[1:0]≠0.
REQ-027 On fault: no memory write; DataOut unchanged; MERR=1 alongside MFC with normal timing.
REQ-028 Address bits above log2(DEPTH) are ignored; addresses wrap modulo DEPTH.

Reset
REQ-029 RESET=1 at an edge: state=IDLE, counter=0, MFC=0, MERR=0, DataOut=0.
REQ-030 RESET overrides all other inputs in the same cycle.
REQ-031 RESET during ACCESS aborts: no memory write occurs, even at the counter=0 edge.
REQ-032 Memory contents are not cleared by RESET.
REQ-033 First request acceptance is possible on the first edge after RESET deasserts.

Verification
REQ-034 LATENCY=2; ST addr 0x10 data 0xDEADBEEF, enable sampled at edge k -> MFC=1 after edge k+2, MERR=0; drop enable -> MFC=0 next edge.
REQ-035 After REQ-034: LDUB 0x10 -> 0x000000DE; LDSB 0x10 -> 0xFFFFFFDE; LDSH 0x12 -> 0xFFFFBEEF; LD 0x10 -> 0xDEADBEEF.
REQ-036 STB 0x11 data 0x00000055 then LD 0x10 -> 0xDE55BEEF.
REQ-037 Faults: LD 0x13 -> MERR=1 with MFC and memory unchanged; LDD -> MERR=1; STH 0x11 -> MERR=1 with no write.
REQ-038 Mid-operation: RESET asserted at the edge before MFC would rise during ST 0x20 -> MFC stays 0 and LD 0x20 returns the prior value; also RAM_enable dropped during ACCESS -> MFC high exactly one cycle.
REQ-039 Address wrap and hold: LD 0x210 with DEPTH=512 returns the data at 0x10; enable held high for 5 cycles in DONE -> MFC and DataOut stable with no second access.
